// File: rtl/hold_grab_controller.sv
`default_nettype none
// ============================================================================
// Module  : hold_grab_controller
// Brief   : Per-frame hold-table scan that attaches each hand to the lowest
//           index hold inside its capture box.
// Rev     : 1.0
// ============================================================================
module hold_grab_controller #(
  parameter int NUM_HOLDS   = 15,
  parameter int IDX_W       = 4,
  parameter int GRAB_RADIUS = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [11:0]       screenx,
  input  logic [12:0]       screeny,
  input  logic [10:0]       hand1x,
  input  logic [9:0]        hand1y,
  input  logic [10:0]       hand2x,
  input  logic [9:0]        hand2y,
  input  logic              grab1,
  input  logic              grab2,
  output logic [IDX_W-1:0]  hold_addr,
  input  logic [11:0]       hold_x,
  input  logic [12:0]       hold_y,
  output logic              held1,
  output logic              held2,
  output logic [IDX_W-1:0]  held1_idx,
  output logic [IDX_W-1:0]  held2_idx,
  output logic              any_held,
  output logic              scan_busy,
  output logic              scan_done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_COMPARE = 2'd2,
    S_UPDATE  = 2'd3
  } state_t;

  localparam logic signed [13:0] C_RAD_P = 14'(GRAB_RADIUS);
  localparam logic signed [13:0] C_RAD_N = -C_RAD_P;
  localparam logic [IDX_W-1:0]   C_LAST  = IDX_W'(NUM_HOLDS - 1);

  state_t             r_state, w_next;
  logic [IDX_W-1:0]   r_idx;
  logic [11:0]        r_sx;
  logic [12:0]        r_sy;
  logic [10:0]        r_h1x, r_h2x;
  logic [9:0]         r_h1y, r_h2y;
  logic               r_g1, r_g2;
  logic               r_c1_v, r_c2_v;
  logic [IDX_W-1:0]   r_c1_idx, r_c2_idx;
  logic               r_held1, r_held2, r_any;
  logic [IDX_W-1:0]   r_held1_idx, r_held2_idx;

  logic               w_last;
  logic signed [13:0] w_hx, w_hy, w_sx, w_sy;
  logic signed [13:0] w_dx1, w_dy1, w_dx2, w_dy2;
  logic               w_m1, w_m2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (frame_start) w_next = S_FETCH;
      S_FETCH:   w_next = S_COMPARE;
      S_COMPARE: w_next = w_last ? S_UPDATE : S_FETCH;
      S_UPDATE:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Hold/scroll are signed and sign-extended; hand coordinates are unsigned.
  assign w_last = (r_idx == C_LAST);
  assign w_hx   = {{2{hold_x[11]}}, hold_x};
  assign w_hy   = {hold_y[12], hold_y};
  assign w_sx   = {{2{r_sx[11]}}, r_sx};
  assign w_sy   = {r_sy[12], r_sy};
  assign w_dx1  = w_hx - w_sx - $signed({3'b000, r_h1x});
  assign w_dy1  = w_hy - w_sy - $signed({4'b0000, r_h1y});
  assign w_dx2  = w_hx - w_sx - $signed({3'b000, r_h2x});
  assign w_dy2  = w_hy - w_sy - $signed({4'b0000, r_h2y});
  assign w_m1   = (w_dx1 >= C_RAD_N) && (w_dx1 <= C_RAD_P) &&
                  (w_dy1 >= C_RAD_N) && (w_dy1 <= C_RAD_P);
  assign w_m2   = (w_dx2 >= C_RAD_N) && (w_dx2 <= C_RAD_P) &&
                  (w_dy2 >= C_RAD_N) && (w_dy2 <= C_RAD_P);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx       <= '0;
      r_sx        <= '0;
      r_sy        <= '0;
      r_h1x       <= '0;
      r_h1y       <= '0;
      r_h2x       <= '0;
      r_h2y       <= '0;
      r_g1        <= 1'b0;
      r_g2        <= 1'b0;
      r_c1_v      <= 1'b0;
      r_c2_v      <= 1'b0;
      r_c1_idx    <= '0;
      r_c2_idx    <= '0;
      r_held1     <= 1'b0;
      r_held2     <= 1'b0;
      r_held1_idx <= '0;
      r_held2_idx <= '0;
      r_any       <= 1'b0;
    end else begin
      r_any <= r_held1 | r_held2;
      if (r_state == S_IDLE && frame_start) begin
        r_sx   <= screenx;
        r_sy   <= screeny;
        r_h1x  <= hand1x;
        r_h1y  <= hand1y;
        r_h2x  <= hand2x;
        r_h2y  <= hand2y;
        r_g1   <= grab1;
        r_g2   <= grab2;
        r_idx  <= '0;
        r_c1_v <= 1'b0;
        r_c2_v <= 1'b0;
      end
      if (r_state == S_COMPARE) begin
        if (w_m1 && !r_c1_v) begin
          r_c1_v   <= 1'b1;
          r_c1_idx <= r_idx;
        end
        if (w_m2 && !r_c2_v) begin
          r_c2_v   <= 1'b1;
          r_c2_idx <= r_idx;
        end
        if (!w_last) r_idx <= r_idx + IDX_W'(1);
      end
      // A live release always wins over an attach in the same cycle.
      if (!grab1) begin
        r_held1 <= 1'b0;
      end else if (r_state == S_UPDATE && r_g1 && !r_held1 && r_c1_v) begin
        r_held1     <= 1'b1;
        r_held1_idx <= r_c1_idx;
      end
      if (!grab2) begin
        r_held2 <= 1'b0;
      end else if (r_state == S_UPDATE && r_g2 && !r_held2 && r_c2_v) begin
        r_held2     <= 1'b1;
        r_held2_idx <= r_c2_idx;
      end
    end
  end

  assign hold_addr = r_idx;
  assign held1     = r_held1;
  assign held2     = r_held2;
  assign held1_idx = r_held1_idx;
  assign held2_idx = r_held2_idx;
  assign any_held  = r_any;
  assign scan_busy = (r_state != S_IDLE);
  assign scan_done = (r_state == S_UPDATE);

endmodule
`default_nettype wire
